// File: rtl/add.sv
// rtl/add.sv - registered ripple-carry adder with valid strobe
// One full-adder cell per bit; result and carry-out captured when in_valid is high.

module add_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  logic p;

  assign p    = a_i ^ b_i;
  assign s_o  = p ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & p);
endmodule

module add #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             c,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             c_out,
  output logic [WIDTH-1:0] sum
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_w;

  logic             valid_q, valid_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] sum_q, sum_d;

  assign carry[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    add_fa u_fa (
      .a_i  (a[i]),
      .b_i  (b[i]),
      .ci_i (carry[i]),
      .s_o  (sum_w[i]),
      .co_o (carry[i+1])
    );
  end

  // Result registers hold their last value while no new operands arrive.
  always_comb begin
    valid_d = in_valid;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (in_valid) begin
      sum_d  = sum_w;
      cout_d = carry[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      cout_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cout_q  <= cout_d;
      sum_q   <= sum_d;
    end
  end

  assign out_valid = valid_q;
  assign c_out     = cout_q;
  assign sum       = sum_q;
endmodule

// File: tb/tb_add.sv
// tb/tb_add.sv - self-checking bench for add at WIDTH 1, 8 and 32
// Reference is plain integer a+b+c with a per-width output state model.

module tb_add;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic        iv1 = 1'b0, c1 = 1'b0;
  logic [0:0]  a1 = '0, b1 = '0;
  logic        ov1, co1;
  logic [0:0]  s1;

  logic        iv8 = 1'b0, c8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ov8, co8;
  logic [7:0]  s8;

  logic        iv32 = 1'b0, c32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ov32, co32;
  logic [31:0] s32;

  add #(.WIDTH(1)) u_add1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .c(c1), .a(a1), .b(b1),
    .out_valid(ov1), .c_out(co1), .sum(s1)
  );
  add #(.WIDTH(8)) u_add8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .c(c8), .a(a8), .b(b8),
    .out_valid(ov8), .c_out(co8), .sum(s8)
  );
  add #(.WIDTH(32)) u_add32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .c(c32), .a(a32), .b(b32),
    .out_valid(ov32), .c_out(co32), .sum(s32)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int          widths [3] = '{1, 8, 32};
  logic        mv [3];
  logic        mc [3];
  logic [63:0] ms [3];

  function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {64'd0, ci};
  endfunction

  // Advance the model by one edge using the currently driven inputs, then check all DUTs.
  task automatic cycle();
    logic        giv [3];
    logic        gc [3];
    logic [63:0] ga [3], gb [3];
    logic        dv [3], dc [3];
    logic [63:0] ds [3];
    logic [64:0] full;
    giv = '{iv1, iv8, iv32};
    gc  = '{c1, c8, c32};
    ga  = '{64'(a1), 64'(a8), 64'(a32)};
    gb  = '{64'(b1), 64'(b8), 64'(b32)};
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mv[k] = 1'b0; mc[k] = 1'b0; ms[k] = '0;
      end else if (giv[k]) begin
        full  = ref_add(ga[k], gb[k], gc[k]);
        mv[k] = 1'b1;
        mc[k] = full[widths[k]];
        ms[k] = full[63:0] & ((64'd1 << widths[k]) - 64'd1);
      end else begin
        mv[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    dv = '{ov1, ov8, ov32};
    dc = '{co1, co8, co32};
    ds = '{64'(s1), 64'(s8), 64'(s32)};
    for (int k = 0; k < 3; k++) begin
      check($sformatf("w%0d out_valid", widths[k]), 64'(dv[k]), 64'(mv[k]));
      check($sformatf("w%0d c_out", widths[k]), 64'(dc[k]), 64'(mc[k]));
      check($sformatf("w%0d sum", widths[k]), ds[k], ms[k]);
    end
  endtask

  task automatic idle_all();
    iv1 = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
  endtask

  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  logic [2:0] idx;

  initial begin
    // Reset
    rst_n = 1'b0;
    iv1 = 1'b1; iv8 = 1'b1; iv32 = 1'b1;
    a8 = 8'h5A; b8 = 8'h33; a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678;
    cycle();
    cycle();
    check("reset out_valid w8", 64'(ov8), 64'd0);
    check("reset sum w32", 64'(s32), 64'd0);
    rst_n = 1'b1;
    idle_all();
    cycle();

    // WIDTH=1 truth table, back-to-back
    iv1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      c1 = idx[2]; a1 = idx[1]; b1 = idx[0];
      cycle();
      check($sformatf("truth cba=%0d", i), 64'({co1, s1}), 64'(tt[i]));
      check($sformatf("truth valid cba=%0d", i), 64'(ov1), 64'd1);
    end
    idle_all();

    // WIDTH=8 wrap
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
    cycle();
    check("wrap1 sum", 64'(s8), 64'h00);
    check("wrap1 c_out", 64'(co8), 64'd1);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    cycle();
    check("wrap2 sum", 64'(s8), 64'hFF);
    check("wrap2 c_out", 64'(co8), 64'd1);

    // Hold
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
    cycle();
    check("hold load sum", 64'(s8), 64'h46);
    iv8 = 1'b0; a8 = 8'hAA; b8 = 8'hBB; c8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold out_valid", 64'(ov8), 64'd0);
      check("hold sum", 64'(s8), 64'h46);
      check("hold c_out", 64'(co8), 64'd0);
    end

    // Back-to-back WIDTH=8
    iv8 = 1'b1;
    a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
    cycle();
    check("b2b0", 64'({ov8, co8, s8}), {54'd0, 1'b1, 1'b0, 8'h02});
    a8 = 8'h02; b8 = 8'h02; c8 = 1'b1;
    cycle();
    check("b2b1", 64'({ov8, co8, s8}), {54'd0, 1'b1, 1'b0, 8'h05});
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
    cycle();
    check("b2b2", 64'({ov8, co8, s8}), {54'd0, 1'b1, 1'b1, 8'h00});

    // Reset priority over in_valid
    rst_n = 1'b0; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    cycle();
    check("rstprio", 64'({ov8, co8, s8}), 64'd0);
    rst_n = 1'b1;
    a8 = 8'h10; b8 = 8'h20; c8 = 1'b0;
    cycle();
    check("fresh after reset", 64'({ov8, co8, s8}), {54'd0, 1'b1, 1'b0, 8'h30});
    idle_all();

    // Random traffic on all widths, with rare mid-stream resets
    for (int n = 0; n < 1200; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      iv1  = 1'($urandom); c1  = 1'($urandom); a1  = 1'($urandom); b1  = 1'($urandom);
      iv8  = 1'($urandom); c8  = 1'($urandom); a8  = 8'($urandom); b8  = 8'($urandom);
      iv32 = 1'($urandom); c32 = 1'($urandom); a32 = $urandom;     b32 = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        a32 = 32'hFFFF_FFFF; a8 = 8'hFF;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
